booth_shift_reg: RTL and testbench

Parametrised product/shift register for the iterative multiply/divide datapath. It generalises the fixed-width enable register into a configurable-width register with these added behaviours:
- parallel load;
- upper-field write-back;
- arithmetic right shift by a configurable amount;
- an internal step counter with busy/done status.

The multdiv control FSM drives it, and it holds the running product or partial remainder across iterations.

---
 rtl/booth_shift_reg.sv | 95 +++++++++
 tb/tb_booth_shift_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/booth_shift_reg.sv
// Product/partial-remainder register for the iterative multdiv datapath:
// parallel load, upper-field write-back, arithmetic right shift and a step counter.
module booth_shift_reg #(
  parameter  int WIDTH = 65,
  parameter  int UPPER = 32,
  parameter  int SHAMT = 2,
  parameter  int STEPS = 16,
  localparam int CW    = $clog2(STEPS + 1)
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             step,
  input  logic             upper_we,
  input  logic [UPPER-1:0] upper_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Mask form keeps UPPER == WIDTH legal (no empty lower slice).
  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [WIDTH-1:0] HI_MASK = ~(ONES >> UPPER);
  localparam logic [CW-1:0]    LAST    = CW'(STEPS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] upper_ext;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    count_inc;

  always_comb begin
    upper_ext = WIDTH'(upper_in) << (WIDTH - UPPER);
    merged    = upper_we ? ((data_q & ~HI_MASK) | upper_ext) : data_q;
    shifted   = $signed(merged) >>> SHAMT;
    count_inc = count_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = BUSY;
      data_d  = data_in;
      count_d = '0;
      busy_d  = 1'b1;
    end else if (state_q == BUSY) begin
      if (step) begin
        data_d  = shifted;
        count_d = count_inc;
        if (count_inc == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end else if (upper_we) begin
        data_d = merged;
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out = data_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_booth_shift_reg.sv
// Directed and randomized bench for booth_shift_reg at default parameters,
// compared against a cycle-level behavioural model of the register.
module tb_booth_shift_reg;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        start;
  logic [64:0] data_in;
  logic        step;
  logic        upper_we;
  logic [31:0] upper_in;
  logic [64:0] data_out;
  logic        busy;
  logic        done;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;

  logic [64:0] m_reg;
  int          m_cnt;
  logic        m_busy;
  logic        m_done;

  booth_shift_reg dut (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .start     (start),
    .data_in   (data_in),
    .step      (step),
    .upper_we  (upper_we),
    .upper_in  (upper_in),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".data"},  data_out, m_reg);
    chk({tag, ".count"}, 65'(count), 65'(m_cnt));
    chk({tag, ".busy"},  65'(busy), 65'(m_busy));
    chk({tag, ".done"},  65'(done), 65'(m_done));
  endtask

  function automatic logic [64:0] asr(input logic [64:0] v, input int n);
    logic [64:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[64], r[64:1]};
    return r;
  endfunction

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic s, input logic [64:0] d, input logic st,
                     input logic uw, input logic [31:0] ui, input string tag);
    logic [64:0] merged;
    start = s; data_in = d; step = st; upper_we = uw; upper_in = ui;
    @(posedge clock);
    merged = uw ? {ui, m_reg[32:0]} : m_reg;
    m_done = 1'b0;
    if (s) begin
      m_reg = d; m_cnt = 0; m_busy = 1'b1;
    end else if (m_busy) begin
      if (st) begin
        m_reg = asr(merged, 2);
        m_cnt = m_cnt + 1;
        if (m_cnt == 16) begin
          m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (uw) begin
        m_reg = merged;
      end
    end
    #1;
    check_model(tag);
  endtask

  task automatic model_reset();
    m_reg = '0; m_cnt = 0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  initial begin
    logic [64:0] r;
    logic [64:0] saved;
    int          done_seen;
    ctrl_reset = 1'b1;
    start = 0; data_in = '0; step = 0; upper_we = 0; upper_in = '0;
    model_reset();
    #12;
    check_model("reset");
    ctrl_reset = 1'b0;

    // Reset mid-operation clears asynchronously, no done pulse afterwards.
    r = {$urandom, $urandom, 1'($urandom)};
    cyc(1, r, 0, 0, '0, "rst_load");
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, '0, "rst_step");
    #2 ctrl_reset = 1'b1;
    #1;
    model_reset();
    chk("rst_async.data", data_out, 65'h0);
    chk("rst_async.count", 65'(count), 65'h0);
    chk("rst_async.busy", 65'(busy), 65'h0);
    chk("rst_async.done", 65'(done), 65'h0);
    ctrl_reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, '0, "rst_after");

    // Full run with sign fill.
    cyc(1, 65'h1_0000_0000_0000_0000, 0, 0, '0, "full_load");
    done_seen = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, '0, 1, 0, '0, "full_step");
      if (done) done_seen++;
    end
    chk("full.data", data_out, 65'h1_FFFF_FFFF_0000_0000);
    chk("full.count", 65'(count), 65'd16);
    chk("full.done_busy", 65'({done, busy}), 65'b10);
    cyc(0, '0, 0, 0, '0, "full_after");
    chk("full.done_drop", 65'(done), 65'h0);
    chk("full.done_pulses", 65'(done_seen), 65'd1);

    // Idle step ignored after done.
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, '0, "idle_step");
    chk("idle.count", 65'(count), 65'd16);
    chk("idle.data", data_out, 65'h1_FFFF_FFFF_0000_0000);

    // Merge plus shift.
    cyc(1, 65'h0_0000_0000_0000_0004, 0, 0, '0, "merge_load");
    cyc(0, '0, 1, 1, 32'h8000_0000, "merge_step");
    chk("merge.data", data_out, 65'h1_C000_0000_0000_0001);
    chk("merge.count", 65'(count), 65'd1);

    // Upper write without shift, in BUSY then in IDLE.
    r = {$urandom, $urandom, 1'($urandom)};
    cyc(1, r, 0, 0, '0, "uw_load");
    cyc(0, '0, 0, 1, 32'h0000_0001, "uw_busy");
    chk("uw.data", data_out, {32'h0000_0001, r[32:0]});
    chk("uw.count", 65'(count), 65'd0);
    for (int i = 0; i < 16; i++) cyc(0, '0, 1, 0, '0, "uw_run");
    saved = data_out;
    cyc(0, '0, 0, 1, 32'h0000_0001, "uw_idle");
    chk("uw_idle.data", data_out, saved);

    // Abort/restart: start wins over step, then 16 more steps needed.
    cyc(1, r, 0, 0, '0, "abort_load");
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, '0, "abort_step");
    cyc(1, 65'h5, 1, 0, '0, "abort_restart");
    chk("abort.data", data_out, 65'h5);
    chk("abort.count_busy_done", 65'({count, busy, done}), 65'b00000_1_0);
    for (int i = 0; i < 15; i++) cyc(0, '0, 1, 0, '0, "abort_run");
    chk("abort.not_done_yet", 65'({busy, done}), 65'b10);
    cyc(0, '0, 1, 0, '0, "abort_last");
    chk("abort.done", 65'({busy, done}), 65'b01);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 19) == 0), {$urandom, $urandom, 1'($urandom)},
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
